mem_port_arbiter: RTL and testbench

- Shares the single BRAM data port (19-bit word address, 32-bit data, 4-bit byte write enable) between the instruction-fetch requester (I) and the exec load/store requester (D).
- Sits between fetch, exec and the BRAM. The BRAM address, write data and write enable are driven combinationally from the granted requester.
- Read data is routed back to its requester by a latency-matched tag pipeline. A starvation guard stops exec memory traffic from locking out fetch.

---
 rtl/mem_pkg.sv | 10 +
 rtl/rd_tag_pipe.sv | 22 ++
 rtl/mem_port_arbiter.sv | 72 +++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: BRAM port widths and read-return tags shared by the arbiter slice
package mem_pkg;
  localparam int MEM_AW = 19;
  localparam int MEM_DW = 32;
  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_I    = 2'b01,
    TAG_D    = 2'b10
  } tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of read-return tags, cleared to TAG_NONE
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t pipe [DEPTH];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= TAG_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one BRAM port between fetch (I) and exec (D) with a starvation guard
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [MEM_AW-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [MEM_DW-1:0] i_rdata,
  input  logic              d_req,
  input  logic [MEM_AW-1:0] d_addr,
  input  logic [MEM_DW-1:0] d_wdata,
  input  logic [3:0]        d_wea,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [MEM_DW-1:0] d_rdata,
  output logic              d_wdone,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic [3:0]        mem_wea,
  output logic              mem_enable,
  input  logic [MEM_DW-1:0] mem_rdata
);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end
  logic [2:0]        starve_cnt;
  logic [MEM_AW-1:0] last_addr;
  logic [MEM_DW-1:0] wdata_q;
  tag_t              tag_in, tag_out;
  // grants are gated by rstn so nothing reaches the BRAM while reset is held
  always_comb begin
    i_gnt      = rstn && i_req && (!d_req || starve_cnt == SMAX);
    d_gnt      = rstn && d_req && !i_gnt;
    mem_enable = i_gnt || d_gnt;
    mem_addr   = i_gnt ? i_addr : d_gnt ? d_addr : last_addr;
    mem_wea    = d_gnt ? d_wea : 4'b0000;
    mem_wdata  = mem_enable ? d_wdata : wdata_q;
    tag_in     = i_gnt ? TAG_I : (d_gnt && d_wea == 4'b0000) ? TAG_D : TAG_NONE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
      last_addr  <= '0;
      wdata_q    <= '0;
      d_wdone    <= 1'b0;
    end else begin
      starve_cnt <= (!i_req || i_gnt) ? 3'd0 : (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 3'd1;
      if (mem_enable) begin
        last_addr <= mem_addr;
        wdata_q   <= d_wdata;
      end
      d_wdone <= d_gnt && (d_wea != 4'b0000);
    end
  end
  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tags (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );
  assign i_rvalid = (tag_out == TAG_I);
  assign d_rvalid = (tag_out == TAG_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: RD_LAT=2 and RD_LAT=1 arbiters on shared stimulus, checked against a transaction model
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  logic clk = 1'b0;
  logic rstn;
  logic i_req, d_req;
  logic [18:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0] d_wea;
  logic a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_d_wdone, a_mem_enable;
  logic b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_d_wdone, b_mem_enable;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [18:0] a_mem_addr, b_mem_addr;
  logic [3:0] a_mem_wea, b_mem_wea;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(2), .STARVE_MAX(STARVE_MAX)) dut_a (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt),
    .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata), .d_req(d_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wea(d_wea), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
    .d_rdata(a_d_rdata), .d_wdone(a_d_wdone), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wea(a_mem_wea), .mem_enable(a_mem_enable),
    .mem_rdata(a_mem_rdata));
  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(STARVE_MAX)) dut_b (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt),
    .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata), .d_req(d_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wea(d_wea), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
    .d_rdata(b_d_rdata), .d_wdone(b_d_wdone), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wea(b_mem_wea), .mem_enable(b_mem_enable),
    .mem_rdata(b_mem_rdata));

  function automatic logic [31:0] init_word(input logic [18:0] a);
    return ({13'h0, a} * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  // BRAM environment: A's port writes the array, each DUT reads with its own latency
  logic [31:0] bram [int];
  logic [31:0] qa0, qa1, qb0;
  function automatic logic [31:0] bram_rd(input logic [18:0] a);
    return bram.exists(int'(a)) ? bram[int'(a)] : init_word(a);
  endfunction
  always @(posedge clk) begin
    logic [31:0] w;
    if (a_mem_enable) begin
      qa0 <= bram_rd(a_mem_addr);
      if (a_mem_wea != 4'b0000) begin
        w = bram_rd(a_mem_addr);
        for (int b = 0; b < 4; b++) if (a_mem_wea[b]) w[8*b +: 8] = a_mem_wdata[8*b +: 8];
        bram[int'(a_mem_addr)] = w;
      end
    end
    qa1 <= qa0;
    if (b_mem_enable) qb0 <= bram_rd(b_mem_addr);
  end
  assign a_mem_rdata = qa1;
  assign b_mem_rdata = qb0;

  // transaction model: pending reads keyed by grant edge, memory as a word map
  typedef struct { int n; bit d; logic [31:0] data; } rd_t;
  rd_t pend [$];
  logic [31:0] ref_mem [int];
  int cyc = 0, starve = 0, wd_edge = -10;
  logic [18:0] m_last = '0;
  logic [31:0] m_wd = '0;
  function automatic logic [31:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction
  function automatic bit exp_i();
    return rstn && i_req && (!d_req || starve == STARVE_MAX);
  endfunction
  always @(posedge clk) begin
    bit gi, gd;
    logic [31:0] w;
    cyc++;
    if (!rstn) begin
      pend.delete(); starve = 0; m_last = '0; m_wd = '0; wd_edge = -10;
    end else begin
      gi = exp_i();
      gd = d_req && !gi;
      if (gi) pend.push_back('{cyc, 1'b0, ref_rd(i_addr)});
      if (gd && d_wea == 4'b0000) pend.push_back('{cyc, 1'b1, ref_rd(d_addr)});
      if (gd && d_wea != 4'b0000) begin
        w = ref_rd(d_addr);
        for (int b = 0; b < 4; b++) if (d_wea[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
        ref_mem[int'(d_addr)] = w;
        wd_edge = cyc;
      end
      if (gi || gd) begin m_last = gi ? i_addr : d_addr; m_wd = d_wdata; end
      starve = (!i_req || gi) ? 0 : (starve == STARVE_MAX) ? STARVE_MAX : starve + 1;
      while (pend.size() > 0 && pend[0].n + 1 < cyc) void'(pend.pop_front());
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_port(input string p, input int lat, input logic ig, dg, men,
                            input logic [3:0] mwe, input logic [18:0] ma, input logic [31:0] mwd,
                            input logic irv, drv, wd, input logic [31:0] ird, drd);
    bit gi, gd, ei, ed;
    logic [31:0] edat;
    gi = exp_i();
    gd = rstn && d_req && !gi;
    ei = 0; ed = 0; edat = '0;
    foreach (pend[k]) if (rstn && pend[k].n + lat - 1 == cyc) begin
      if (pend[k].d) ed = 1; else ei = 1;
      edat = pend[k].data;
    end
    chk({p, ".i_gnt"}, 64'(ig), 64'(gi));
    chk({p, ".d_gnt"}, 64'(dg), 64'(gd));
    chk({p, ".mem_enable"}, 64'(men), 64'(gi || gd));
    chk({p, ".mem_wea"}, 64'(mwe), 64'(gd ? d_wea : 4'b0));
    chk({p, ".mem_addr"}, 64'(ma), 64'(!rstn ? 19'h0 : gi ? i_addr : gd ? d_addr : m_last));
    chk({p, ".mem_wdata"}, 64'(mwd), 64'(!rstn ? 32'h0 : (gi || gd) ? d_wdata : m_wd));
    chk({p, ".i_rvalid"}, 64'(irv), 64'(ei));
    chk({p, ".d_rvalid"}, 64'(drv), 64'(ed));
    chk({p, ".d_wdone"}, 64'(wd), 64'(rstn && wd_edge == cyc));
    if (ei) chk({p, ".i_rdata"}, 64'(ird), 64'(edat));
    if (ed) chk({p, ".d_rdata"}, 64'(drd), 64'(edat));
  endtask

  always @(negedge clk) begin
    check_port("A", 2, a_i_gnt, a_d_gnt, a_mem_enable, a_mem_wea, a_mem_addr, a_mem_wdata,
               a_i_rvalid, a_d_rvalid, a_d_wdone, a_i_rdata, a_d_rdata);
    check_port("B", 1, b_i_gnt, b_d_gnt, b_mem_enable, b_mem_wea, b_mem_addr, b_mem_wdata,
               b_i_rvalid, b_d_rvalid, b_d_wdone, b_i_rdata, b_d_rdata);
  end

  logic s_ig, s_dg, s_men, s_wdone, s_airv, s_adrv, s_birv, s_bdrv;
  logic [3:0] s_mwe;
  logic [18:0] s_addr;
  logic [31:0] s_aird, s_adrd, s_bird;

  task automatic step();
    @(negedge clk);
    s_ig = a_i_gnt; s_dg = a_d_gnt; s_men = a_mem_enable; s_mwe = a_mem_wea;
    s_addr = a_mem_addr; s_wdone = a_d_wdone;
    s_airv = a_i_rvalid; s_adrv = a_d_rvalid; s_aird = a_i_rdata; s_adrd = a_d_rdata;
    s_birv = b_i_rvalid; s_bdrv = b_d_rvalid; s_bird = b_i_rdata;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] rand_addr();
    return 19'($urandom_range(15)) | ($urandom_range(1) ? 19'h200 : 19'h0);
  endfunction

  initial begin
    logic [11:0] ipat;
    logic [4:0] rpat;
    logic [31:0] old_w;
    rstn = 1'b0; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wea = '0;
    step(); step();
    rstn = 1'b1;
    step(); step();
    // I-only read
    i_req = 1; i_addr = 19'h00010;
    step();
    chk("ionly.i_gnt", 64'(s_ig), 64'h1);
    chk("ionly.mem_addr", 64'(s_addr), 64'h10);
    i_req = 0;
    step();
    chk("lat1.i_rvalid", 64'(s_birv), 64'h1);
    chk("lat1.i_rdata", 64'(s_bird), 64'(init_word(19'h10)));
    chk("ionly.early_rvalid", 64'(s_airv), 64'h0);
    step();
    chk("ionly.i_rvalid", 64'(s_airv), 64'h1);
    chk("ionly.i_rdata", 64'(s_aird), 64'(init_word(19'h10)));
    chk("ionly.d_rvalid", 64'(s_adrv), 64'h0);
    // D store then load
    d_req = 1; d_addr = 19'h00200; d_wea = 4'b0010; d_wdata = 32'h0000AB00;
    old_w = init_word(19'h200);
    step();
    chk("store.d_gnt", 64'(s_dg), 64'h1);
    chk("store.mem_wea", 64'(s_mwe), 64'h2);
    d_req = 0; d_wea = 4'b0000;
    step();
    chk("store.d_wdone", 64'(s_wdone), 64'h1);
    d_req = 1;
    step();
    chk("store.wdone_once", 64'(s_wdone), 64'h0);
    d_req = 0;
    step(); step();
    chk("load.d_rvalid", 64'(s_adrv), 64'h1);
    chk("load.d_rdata", 64'(s_adrd), 64'((old_w & 32'hFFFF00FF) | 32'h0000AB00));
    // contention and starvation
    i_req = 1; i_addr = 19'h5; d_req = 1; d_addr = 19'h6; d_wea = 0;
    for (int k = 0; k < 12; k++) begin step(); ipat[k] = s_ig; end
    chk("starve.pattern", 64'(ipat), 64'h210);
    i_req = 0; d_req = 0;
    step(); step(); step();
    // back-to-back interleave
    for (int k = 0; k < 6; k++) begin
      i_req = (k % 2 == 0); i_addr = 19'(k);
      d_req = (k % 2 == 1); d_addr = 19'h200 + 19'(k);
      step();
    end
    i_req = 0; d_req = 0;
    step(); step(); step();
    // reset while a read is in flight and starvation count is non-zero
    i_req = 1; d_req = 1; i_addr = 19'h33; d_addr = 19'h44;
    step(); step(); step();
    rstn = 0; d_wea = 4'hF;
    step();
    chk("reset.i_gnt", 64'(s_ig), 64'h0);
    chk("reset.d_gnt", 64'(s_dg), 64'h0);
    chk("reset.mem_wea", 64'(s_mwe), 64'h0);
    chk("reset.mem_enable", 64'(s_men), 64'h0);
    rstn = 1; d_wea = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      rpat[k] = s_ig;
      if (k == 0) chk("reset.no_rvalid", 64'({s_airv, s_adrv, s_birv, s_bdrv}), 64'h0);
    end
    chk("reset.starve_restart", 64'(rpat), 64'h10);
    i_req = 0; d_req = 0;
    step(); step();
    // randomized traffic obeying hold-until-grant, with occasional withdrawals
    for (int k = 0; k < 1500; k++) begin
      if (i_req && !s_ig) begin
        if ($urandom_range(9) == 0) i_req = 0;
      end else begin
        i_req = ($urandom_range(3) != 0); i_addr = rand_addr();
      end
      if (d_req && !s_dg) begin
        if ($urandom_range(9) == 0) d_req = 0;
      end else begin
        d_req = ($urandom_range(3) != 0); d_addr = rand_addr();
        d_wdata = $urandom(); d_wea = $urandom_range(1) ? 4'($urandom_range(15)) : 4'h0;
      end
      step();
    end
    i_req = 0; d_req = 0;
    step(); step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
